// File: rtl/solver_dispatch.sv
`timescale 1ns/1ps
// solver_dispatch: task FIFO feeding the endgame solver and a result
// FIFO collecting its scores, with credit-gated dispatch.
module solver_dispatch #(
  parameter int TDEPTH = 16,
  parameter int RDEPTH = 16,
  parameter int NSLOT  = 8
) (
  input  logic               iCLOCK,
  input  logic               iRESET_N,
  input  logic               task_valid,
  output logic               task_ready,
  input  logic [63:0]        task_player,
  input  logic [63:0]        task_opponent,
  input  logic [15:0]        task_id,
  output logic               oEnable,
  output logic               oValid,
  output logic [63:0]        oPlayer,
  output logic [63:0]        oOpponent,
  output logic [15:0]        oTaskid,
  input  logic               iSolved,
  input  logic [15:0]        iSolverTaskid,
  input  logic signed [7:0]  iRes,
  input  logic [15:0]        iNodes,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_taskid,
  output logic signed [7:0]  res_score,
  output logic [15:0]        res_nodes,
  output logic [4:0]         busy,
  output logic               oBadId,
  output logic               oProtoErr
);

  localparam int TAW = $clog2(TDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int WW  = $clog2(2 * NSLOT);
  localparam logic [15:0] IDLE_ID = 16'hffff;
  localparam logic [TAW:0] TFULL = (TAW + 1)'(TDEPTH);
  localparam logic [WW-1:0] WLAST = WW'(2 * NSLOT - 1);

  typedef enum logic {WARMUP, RUN} state_t;

  state_t state;
  logic [WW-1:0] wcnt;

  logic [63:0] tpl_mem [TDEPTH];
  logic [63:0] top_mem [TDEPTH];
  logic [15:0] tid_mem [TDEPTH];
  logic [TAW-1:0] twr, trd;
  logic [TAW:0] tcnt;

  logic [39:0] rmem [RDEPTH];
  logic [RAW-1:0] rwr, rrd;
  logic [RAW:0] rcnt;

  logic t_push, bad_push, cap_req, cap, r_pop;
  logic slot_ok;
  logic [15:0] reserved;

  assign task_ready = iRESET_N & (tcnt != TFULL);
  assign t_push = task_valid & task_ready & (task_id != IDLE_ID);
  assign bad_push = task_valid & task_ready & (task_id == IDLE_ID);

  assign cap_req = iSolved & (iSolverTaskid != IDLE_ID);
  assign cap = cap_req & (busy != 5'd0);

  // The context finishing now is the one being refilled, so it
  // does not count against the slot limit.
  assign slot_ok = (busy < 5'(NSLOT)) | cap;
  assign reserved = 16'(rcnt) + 16'(busy);

  assign oValid = iSolved & (state == RUN) & (tcnt != '0)
                & (reserved < 16'(RDEPTH)) & slot_ok;

  assign oPlayer = oValid ? tpl_mem[trd] : 64'd0;
  assign oOpponent = oValid ? top_mem[trd] : 64'd0;
  assign oTaskid = oValid ? tid_mem[trd] : IDLE_ID;

  assign res_valid = (rcnt != '0);
  assign r_pop = res_valid & res_ready;
  assign {res_taskid, res_score, res_nodes} =
    res_valid ? rmem[rrd] : 40'd0;

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state <= WARMUP;
      wcnt <= '0;
      oEnable <= 1'b0;
    end else begin
      unique case (state)
        WARMUP: begin
          if (wcnt == WLAST) begin
            state <= RUN;
            oEnable <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        RUN: oEnable <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (t_push) begin
      tpl_mem[twr] <= task_player;
      top_mem[twr] <= task_opponent;
      tid_mem[twr] <= task_id;
    end
    if (cap) rmem[rwr] <= {iSolverTaskid, iRes, iNodes};
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      twr <= '0;
      trd <= '0;
      tcnt <= '0;
    end else begin
      if (t_push) twr <= twr + TAW'(1);
      if (oValid) trd <= trd + TAW'(1);
      unique case (1'b1)
        (t_push & !oValid): tcnt <= tcnt + (TAW + 1)'(1);
        (oValid & !t_push): tcnt <= tcnt - (TAW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      rwr <= '0;
      rrd <= '0;
      rcnt <= '0;
    end else begin
      if (cap) rwr <= rwr + RAW'(1);
      if (r_pop) rrd <= rrd + RAW'(1);
      unique case (1'b1)
        (cap & !r_pop): rcnt <= rcnt + (RAW + 1)'(1);
        (r_pop & !cap): rcnt <= rcnt - (RAW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      busy <= 5'd0;
      oBadId <= 1'b0;
      oProtoErr <= 1'b0;
    end else begin
      unique case (1'b1)
        (oValid & !cap): busy <= busy + 5'd1;
        (cap & !oValid): busy <= busy - 5'd1;
        default: ;
      endcase
      if (bad_push) oBadId <= 1'b1;
      if (cap_req & (busy == 5'd0)) oProtoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_solver_dispatch.sv
`timescale 1ns/1ps
// tb_solver_dispatch: directed bench with a fixed-latency solver model,
// one default instance and one with a 4-entry result FIFO.
module tb_solver_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  logic task_valid;
  logic [63:0] task_player, task_opponent;
  logic [15:0] task_id;
  logic iSolved;
  logic [15:0] sid;
  logic [7:0] iRes;
  logic [15:0] iNodes;
  logic res_ready;

  logic a_tr, a_en, a_ov, a_rv, a_bad, a_perr;
  logic [63:0] a_pl, a_op;
  logic [15:0] a_tid, a_rtid, a_rnd;
  logic [7:0] a_rsc;
  logic [4:0] a_busy;

  logic b_tr, b_en, b_ov, b_rv, b_bad, b_perr;
  logic [63:0] b_pl, b_op;
  logic [15:0] b_tid, b_rtid, b_rnd;
  logic [7:0] b_rsc;
  logic [4:0] b_busy;

  logic sel = 1'b0;
  logic v_tr, v_en, v_ov, v_rv, v_bad, v_perr;
  logic [63:0] v_pl, v_op;
  logic [15:0] v_tid, v_rtid, v_rnd;
  logic [7:0] v_rsc;
  logic [4:0] v_busy;

  int n_chk = 0;
  int n_err = 0;
  int ovf = 0;

  always #5 clk = ~clk;

  solver_dispatch dut_a (
    .iCLOCK(clk), .iRESET_N(rst_n),
    .task_valid(task_valid), .task_ready(a_tr),
    .task_player(task_player), .task_opponent(task_opponent),
    .task_id(task_id), .oEnable(a_en), .oValid(a_ov),
    .oPlayer(a_pl), .oOpponent(a_op), .oTaskid(a_tid),
    .iSolved(iSolved), .iSolverTaskid(sid),
    .iRes(iRes), .iNodes(iNodes),
    .res_valid(a_rv), .res_ready(res_ready),
    .res_taskid(a_rtid), .res_score(a_rsc), .res_nodes(a_rnd),
    .busy(a_busy), .oBadId(a_bad), .oProtoErr(a_perr)
  );

  solver_dispatch #(.RDEPTH(4)) dut_b (
    .iCLOCK(clk), .iRESET_N(rst_n),
    .task_valid(task_valid), .task_ready(b_tr),
    .task_player(task_player), .task_opponent(task_opponent),
    .task_id(task_id), .oEnable(b_en), .oValid(b_ov),
    .oPlayer(b_pl), .oOpponent(b_op), .oTaskid(b_tid),
    .iSolved(iSolved), .iSolverTaskid(sid),
    .iRes(iRes), .iNodes(iNodes),
    .res_valid(b_rv), .res_ready(res_ready),
    .res_taskid(b_rtid), .res_score(b_rsc), .res_nodes(b_rnd),
    .busy(b_busy), .oBadId(b_bad), .oProtoErr(b_perr)
  );

  assign v_tr = sel ? b_tr : a_tr;
  assign v_en = sel ? b_en : a_en;
  assign v_ov = sel ? b_ov : a_ov;
  assign v_rv = sel ? b_rv : a_rv;
  assign v_bad = sel ? b_bad : a_bad;
  assign v_perr = sel ? b_perr : a_perr;
  assign v_pl = sel ? b_pl : a_pl;
  assign v_op = sel ? b_op : a_op;
  assign v_tid = sel ? b_tid : a_tid;
  assign v_rtid = sel ? b_rtid : a_rtid;
  assign v_rnd = sel ? b_rnd : a_rnd;
  assign v_rsc = sel ? b_rsc : a_rsc;
  assign v_busy = sel ? b_busy : a_busy;

  // A capture must never meet a full result FIFO.
  always @(posedge clk) begin
    if (rst_n && iSolved && sid != 16'hffff) begin
      if (a_busy != 0 && dut_a.rcnt == 5'd16) ovf++;
      if (b_busy != 0 && dut_b.rcnt == 3'd4) ovf++;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] score_of(input logic [15:0] id);
    return 8'(id * 5) - 8'd40;
  endfunction

  function automatic logic [15:0] nodes_of(input logic [15:0] id);
    return 16'(id * 3 + 7);
  endfunction

  logic o_ov, o_rv, o_tr;
  logic [63:0] o_pl, o_op;
  logic [15:0] o_tid, o_rtid, o_rnd;
  logic [7:0] o_rsc;

  task automatic tick(input logic sv, input logic [15:0] s,
                      input logic [7:0] r, input logic [15:0] nd,
                      input logic tv, input logic [15:0] tid,
                      input logic rr);
    iSolved = sv;
    sid = s;
    iRes = r;
    iNodes = nd;
    task_valid = tv;
    task_id = tid;
    task_player = {4{tid}};
    task_opponent = ~{4{tid}};
    res_ready = rr;
    #1;
    o_ov = v_ov; o_tid = v_tid; o_pl = v_pl; o_op = v_op;
    o_rv = v_rv; o_rtid = v_rtid; o_rsc = v_rsc;
    o_rnd = v_rnd; o_tr = v_tr;
    @(negedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 16'hffff, 8'd0, 16'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iSolved = 1'b0;
    task_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  logic [15:0] fl_id[$];
  int fl_due[$];
  logic [15:0] disp_q[$];
  logic [15:0] rc_id[$];
  logic [7:0] rc_sc[$];
  int busy_at[64];
  int disp_at[64];

  task automatic run_model(input int n, input int ntask,
                           input logic [15:0] base,
                           input int rlo, input int rhi);
    int pushed;
    pushed = 0;
    fl_id.delete(); fl_due.delete(); disp_q.delete();
    rc_id.delete(); rc_sc.delete();
    for (int c = 0; c < n; c++) begin
      logic [15:0] s;
      logic tv, rr;
      busy_at[c] = int'(v_busy);
      s = 16'hffff;
      if (fl_id.size() > 0 && fl_due[0] == c) begin
        s = fl_id.pop_front();
        void'(fl_due.pop_front());
      end
      tv = (pushed < ntask);
      rr = (c >= rlo && c <= rhi);
      tick(1'b1, s, score_of(s), nodes_of(s),
           tv, base + 16'(pushed), rr);
      if (o_ov) begin
        fl_id.push_back(o_tid);
        fl_due.push_back(c + 8);
        disp_q.push_back(o_tid);
      end
      if (o_rv && rr) begin
        rc_id.push_back(o_rtid);
        rc_sc.push_back(o_rsc);
      end
      if (tv && o_tr) pushed++;
      disp_at[c] = disp_q.size();
    end
  endtask

  initial begin
    int dev, nrv, nov, enbad;
    rst_n = 1'b0;
    task_valid = 1'b0; task_id = 16'd0;
    task_player = 64'd0; task_opponent = 64'd0;
    iSolved = 1'b0; sid = 16'hffff;
    iRes = 8'd0; iNodes = 16'd0; res_ready = 1'b0;
    #12;
    check("rst_tready", v_tr, 1'b0);
    check("rst_en", v_en, 1'b0);
    check("rst_ovalid", v_ov, 1'b0);
    check("rst_opl", v_pl, 64'd0);
    check("rst_oop", v_op, 64'd0);
    check("rst_otid", v_tid, 16'hffff);
    check("rst_rvalid", v_rv, 1'b0);
    check("rst_rtid", v_rtid, 16'd0);
    check("rst_rsc", v_rsc, 8'd0);
    check("rst_rnd", v_rnd, 16'd0);
    check("rst_busy", v_busy, 5'd0);
    check("rst_badid", v_bad, 1'b0);
    check("rst_perr", v_perr, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("warm_en", v_en, 1'b0);
      @(negedge clk);
    end
    check("run_en", v_en, 1'b1);
    check("run_tready", v_tr, 1'b1);

    // single task
    tick(1'b0, 16'hffff, 8'd0, 16'd0, 1'b1, 16'h0001, 1'b0);
    tick(1'b1, 16'hffff, 8'd0, 16'd0, 1'b0, 16'h0000, 1'b0);
    check("disp_valid", o_ov, 1'b1);
    check("disp_tid", o_tid, 16'h0001);
    check("disp_pl", o_pl, {4{16'h0001}});
    check("disp_op", o_op, ~{4{16'h0001}});
    check("disp_busy", v_busy, 5'd1);
    tick(1'b1, 16'h0001, 8'd12, 16'd345, 1'b0, 16'h0000, 1'b0);
    check("idle_valid", o_ov, 1'b0);
    check("idle_tid", o_tid, 16'hffff);
    check("idle_pl", o_pl, 64'd0);
    check("cap_rvalid", v_rv, 1'b1);
    check("cap_rtid", v_rtid, 16'h0001);
    check("cap_rsc", v_rsc, 8'd12);
    check("cap_rnd", v_rnd, 16'd345);
    check("cap_busy", v_busy, 5'd0);
    idle();
    check("hold_rtid", v_rtid, 16'h0001);
    tick(1'b0, 16'hffff, 8'd0, 16'd0, 1'b0, 16'd0, 1'b1);
    check("pop_seen", o_rv, 1'b1);
    check("pop_rvalid", v_rv, 1'b0);

    // push and opportunity in the same cycle
    tick(1'b1, 16'hffff, 8'd0, 16'd0, 1'b1, 16'h0002, 1'b0);
    check("lat_same", o_ov, 1'b0);
    tick(1'b1, 16'hffff, 8'd0, 16'd0, 1'b0, 16'h0000, 1'b0);
    check("lat_next", o_ov, 1'b1);
    check("lat_tid", o_tid, 16'h0002);
    tick(1'b1, 16'h0002, 8'hfb, 16'd7, 1'b0, 16'h0000, 1'b0);
    check("neg_rsc", v_rsc, 8'hfb);
    tick(1'b0, 16'hffff, 8'd0, 16'd0, 1'b0, 16'd0, 1'b1);

    // errors
    tick(1'b0, 16'hffff, 8'd0, 16'd0, 1'b1, 16'hffff, 1'b0);
    check("bad_flag", v_bad, 1'b1);
    tick(1'b1, 16'hffff, 8'd0, 16'd0, 1'b0, 16'h0000, 1'b0);
    check("bad_nodisp", o_ov, 1'b0);
    tick(1'b1, 16'h0007, 8'd1, 16'd1, 1'b0, 16'h0000, 1'b0);
    check("perr_flag", v_perr, 1'b1);
    check("perr_rvalid", v_rv, 1'b0);
    check("perr_busy", v_busy, 5'd0);

    // full pipeline
    do_reset();
    check("rst2_badid", v_bad, 1'b0);
    check("rst2_perr", v_perr, 1'b0);
    run_model(36, 20, 16'h0100, 0, 1000);
    dev = 0;
    for (int c = 9; c <= 21; c++) if (busy_at[c] != 8) dev++;
    check("busy_steady", dev, 0);
    check("busy_drain", busy_at[22], 7);
    check("steady_disp", disp_q.size(), 20);
    check("steady_nres", rc_id.size(), 20);
    for (int i = 0; i < 20 && i < rc_id.size(); i++) begin
      check("steady_id", rc_id[i], 16'h0100 + 16'(i));
      check("steady_sc", rc_sc[i], score_of(16'h0100 + 16'(i)));
    end

    // credit stall on the 4-entry result FIFO
    do_reset();
    sel = 1'b1;
    run_model(41, 10, 16'h0200, 21, 22);
    check("credit_first", disp_at[20], 4);
    check("credit_total", disp_q.size(), 6);
    check("credit_pops", rc_id.size(), 2);
    if (rc_id.size() == 2) begin
      check("credit_pop0", rc_id[0], 16'h0200);
      check("credit_pop1", rc_id[1], 16'h0201);
    end
    sel = 1'b0;

    // reset mid-run
    do_reset();
    run_model(11, 5, 16'h0300, -1, -1);
    check("mid_busy", v_busy, 5'd3);
    check("mid_rvalid", v_rv, 1'b1);
    rst_n = 1'b0;
    iSolved = 1'b0;
    task_valid = 1'b0;
    #1;
    check("async_rvalid", v_rv, 1'b0);
    check("async_busy", v_busy, 5'd0);
    check("async_en", v_en, 1'b0);
    check("async_tready", v_tr, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0; nov = 0; enbad = 0;
    for (int i = 0; i < 40; i++) begin
      if ((i < 16) == v_en) enbad++;
      tick(1'b1, 16'hffff, 8'd0, 16'd0, 1'b0, 16'd0, 1'b1);
      if (o_rv) nrv++;
      if (o_ov) nov++;
    end
    check("mid_warm", enbad, 0);
    check("mid_stale_res", nrv, 0);
    check("mid_stale_disp", nov, 0);
    check("ovf_guard", ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
